axis_fifo_buf: RTL
==================

// Module: axis_fifo_buf
// PURPOSE
//  Parametrised AXI-Stream elastic buffer: DEPTH-entry circular FIFO with tlast,
//  registered tvalid_o/tready_o/tdata_o. Full throughput (1 beat/clk), no
//  combinational path between the two sides. Generalises the 2-entry register
//  slice; sits between stream producers/consumers to absorb backpressure bursts.
// PARAMETERS
//  DATA_WIDTH  8   tdata width in bits (>=1)
//  DEPTH       4   storage entries; power of two, >=2
//  AF_LEVEL    3   almost-full threshold, 1..DEPTH (used only with AXIS_FIFO_LEVEL_EN)
// PORTS
//  clk_i        in   1               clock, all logic on rising edge
//  arstn_i      in   1               reset, asynchronous, active-high (1 = reset)
//  tvalid_i     in   1               upstream valid
//  tready_o     out  1               upstream ready (registered)
//  tdata_i      in   DATA_WIDTH      upstream data
//  tlast_i      in   1               upstream packet end
//  tvalid_o     out  1               downstream valid (registered)
//  tready_i     in   1               downstream ready
//  tdata_o      out  DATA_WIDTH      downstream data (registered)
//  tlast_o      out  1               downstream packet end (registered)
//  level_o      out  $clog2(DEPTH)+1 entries held (AXIS_FIFO_LEVEL_EN only)
//  almost_full_o out 1               level >= AF_LEVEL (AXIS_FIFO_LEVEL_EN only)
// BEHAVIOUR
//  - Reset (arstn_i=1, async): tvalid_o=0, tready_o=1, tdata_o=0, tlast_o=0,
//    count=0, wr/rd pointers=0; level_o=0, almost_full_o=0. Reset mid-transfer
//    discards all content; first beat after release is accepted normally.
//  - push = tvalid_i & tready_o; pop = tvalid_o & tready_i.
//  - count (log2(DEPTH)+1 bits): +1 on push only, -1 on pop only, unchanged
//    on push&pop. Never exceeds DEPTH, never underflows.
//  - tready_o = registered (next_count != DEPTH); tvalid_o = registered
//    (next_count != 0). No bypass: full + pop raises tready_o one cycle later;
//    empty + push raises tvalid_o one cycle later.
//  - Latency: beat pushed at edge N appears on tdata_o/tlast_o with tvalid_o=1
//    from edge N onward (visible cycle N+1) when FIFO was empty.
//  - {tdata_o,tlast_o} always = oldest stored beat while tvalid_o=1; held stable
//    while tvalid_o & !tready_i (AXI-S rule). Order strictly FIFO.
//  - Pointers log2(DEPTH) bits, wrap DEPTH-1 -> 0 naturally.
//  - Pop at count=1 with simultaneous push: new beat becomes head next cycle,
//    tvalid_o stays 1 (no bubble). Push&pop at count=DEPTH impossible (tready_o=0).
//  - tdata_o/tlast_o retain last value when empty; content undefined-to-use.
//  - tdata_i/tlast_i ignored when !push. Behaviour with tvalid_i dropping before
//    acceptance is upstream's violation; buffer only samples on push.
// CONFIGURATION
//  AXIS_FIFO_LEVEL_EN defined: level_o and almost_full_o ports exist; both
//    registered, equal count and (count >= AF_LEVEL) after each edge.
//  Not defined: ports absent, no extra logic; data path identical.
// TESTING
//  1 Reset: arstn_i=1 pulse mid-stream -> tvalid_o=0, tready_o=1, tdata_o=0 at once.
//  2 Streaming: DEPTH=4, tvalid_i=1, tready_i=1, data 1..100 -> 100 beats out in
//    order, one per clk after 1-cycle latency, tready_o never drops.
//  3 Fill: tready_i=0, push 0xA1..0xA4 -> tready_o=0 after 4th push; 0xA5 held
//    upstream; tready_i=1 -> out A1,A2,A3,A4,A5; tready_o=1 one clk after 1st pop.
//  4 Wrap: random tvalid_i/tready_i (50%), 1000 beats, DEPTH=8 -> scoreboard match,
//    tdata_o stable on every stalled cycle, count in 0..8.
//  5 tlast: packets of length 1,3,5 -> tlast_o=1 only on beats 1,4,9.
//  6 LEVEL_EN, AF_LEVEL=3: push 3 with tready_i=0 -> level_o=3, almost_full_o=1;
//    pop 1 -> level_o=2, almost_full_o=0.

Source files
------------

// File: rtl/axis_fifo_buf.sv
// ============================================================================
// axis_fifo_buf : AXI-Stream elastic buffer, DEPTH-entry circular FIFO, registered outputs.
// Optional level_o/almost_full_o ports when AXIS_FIFO_LEVEL_EN is defined.
// Revision 1.0
// ============================================================================
`default_nettype none

module axis_fifo_buf #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 4,
   parameter int AF_LEVEL   = 3
) (
   input  logic                  clk_i,
   input  logic                  arstn_i,
   input  logic                  tvalid_i,
   output logic                  tready_o,
   input  logic [DATA_WIDTH-1:0] tdata_i,
   input  logic                  tlast_i,
   output logic                  tvalid_o,
   input  logic                  tready_i,
   output logic [DATA_WIDTH-1:0] tdata_o,
   output logic                  tlast_o
`ifdef AXIS_FIFO_LEVEL_EN
   ,
   output logic [$clog2(DEPTH):0] level_o,
   output logic                   almost_full_o
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   generate
      if ((DEPTH < 2) || ((1 << PTR_W) != DEPTH) || (AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_bad_params
         $error("axis_fifo_buf: DEPTH must be a power of two >= 2 and AF_LEVEL in 1..DEPTH");
      end
   endgenerate

   logic [DATA_WIDTH:0] mem_q [DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [CNT_W-1:0]    w_cnt_after_pop;
   logic [DATA_WIDTH:0] head_q, head_d;
   logic                tvalid_q, tready_q;
   logic                w_push, w_pop;

   assign w_push = tvalid_i & tready_q;
   assign w_pop  = tvalid_q & tready_i;

   always_comb begin
      wr_ptr_d        = wr_ptr_q;
      rd_ptr_d        = rd_ptr_q;
      w_cnt_after_pop = count_q;
      head_d          = head_q;
      if (w_push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (w_pop) begin
         rd_ptr_d        = rd_ptr_q + PTR_W'(1);
         w_cnt_after_pop = count_q - CNT_W'(1);
      end
      count_d = w_push ? (w_cnt_after_pop + CNT_W'(1)) : w_cnt_after_pop;
      // An incoming beat landing in an otherwise empty FIFO is not yet in
      // storage, so it has to be forwarded straight into the head register.
      if (w_push && (w_cnt_after_pop == '0)) begin
         head_d = {tlast_i, tdata_i};
      end else if (count_d != '0) begin
         head_d = mem_q[rd_ptr_d];
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         mem_q[wr_ptr_q] <= {tlast_i, tdata_i};
      end
   end

   always_ff @(posedge clk_i or posedge arstn_i) begin
      if (arstn_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
         tvalid_q <= 1'b0;
         tready_q <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
         tvalid_q <= (count_d != '0);
         tready_q <= (count_d != FULL_CNT);
      end
   end

   assign tvalid_o = tvalid_q;
   assign tready_o = tready_q;
   assign tdata_o  = head_q[DATA_WIDTH-1:0];
   assign tlast_o  = head_q[DATA_WIDTH];

`ifdef AXIS_FIFO_LEVEL_EN
   localparam logic [CNT_W-1:0] AF_CNT = CNT_W'(AF_LEVEL);

   logic af_q;

   always_ff @(posedge clk_i or posedge arstn_i) begin
      if (arstn_i) begin
         af_q <= 1'b0;
      end else begin
         af_q <= (count_d >= AF_CNT);
      end
   end

   assign level_o       = count_q;
   assign almost_full_o = af_q;
`endif

endmodule

`default_nettype wire
